// File: rtl/urate_pkg.sv
// Shared types and sizing for the unary-rate multiply-accumulate stage.
package urate_pkg;
  localparam int URATE_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} urate_state_t;
endpackage

// File: rtl/urate_mul_acc_if.sv
// Operand, stream, Sobol and result signals of urate_mul_acc grouped as one bus.
interface urate_mul_acc_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] iA;
  logic [WIDTH:0]   cycles;
  logic             iB_bit;
  logic             iB_valid;
  logic [WIDTH-1:0] sobol_seq;
  logic             sobol_en;
  logic             oBit;
  logic             oBit_valid;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   oC;

  modport master (
    output start, iA, cycles, iB_bit, iB_valid, sobol_seq,
    input  sobol_en, oBit, oBit_valid, busy, done, oC
  );
  modport slave (
    input  start, iA, cycles, iB_bit, iB_valid, sobol_seq,
    output sobol_en, oBit, oBit_valid, busy, done, oC
  );
endinterface

// File: rtl/urate_len_cnt.sv
// Loadable window-length down-counter; last flags the final consumed cycle.
module urate_len_cnt #(parameter int W = 17) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         dec,
  output logic         last
);
  logic [W-1:0] rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  rem <= '0;
    else if (load)               rem <= din;
    else if (dec && rem != '0)   rem <= rem - W'(1);
  end

  assign last = (rem == W'(1));
endmodule

// File: rtl/urate_mul_acc.sv
// Rate-codes iA against the Sobol sample, ANDs with the unary iB stream and counts ones over a window.
module urate_mul_acc
  import urate_pkg::*;
#(
  parameter int WIDTH = URATE_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  urate_mul_acc_if.slave bus
);
  urate_state_t     state;
  logic [WIDTH-1:0] ia_q;
  logic             take, consume, last, p;

  assign take        = bus.start && (state != RUN);
  assign consume     = (state == RUN) && bus.iB_valid;
  assign bus.sobol_en = consume;
  // Strict compare: a sample of all ones never counts, even for iA = all ones.
  assign p           = bus.iB_bit & (ia_q > bus.sobol_seq);

  urate_len_cnt #(.W(WIDTH+1)) u_len (
    .clk  (clk),
    .rst_n(rst_n),
    .load (take),
    .din  (bus.cycles),
    .dec  (consume),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ia_q           <= '0;
      bus.oC         <= '0;
      bus.oBit       <= 1'b0;
      bus.oBit_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.oBit_valid <= consume;
      bus.done       <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            ia_q   <= bus.iA;
            bus.oC <= '0;
            if (bus.cycles == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
            end
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        RUN: begin
          if (consume) begin
            bus.oC   <= bus.oC + {{WIDTH{1'b0}}, p};
            bus.oBit <= p;
            if (last) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_urate_mul_acc.sv
// Directed, table-driven bench for urate_mul_acc with a bit-reversed-counter Sobol model.
module tb_urate_mul_acc;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0] ia;
    logic [W:0]   cyc;
    int           alt;
    int           stall_at;
    int           stall_len;
    int           poke;
    logic [W:0]   exp_oc;
    int           exp_lat;
    int           exp_en;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sob_clr = 1'b0;
  logic [W-1:0] k;
  int checks = 0;
  int errors = 0;
  vec_t vecs[6];

  urate_mul_acc_if #(.WIDTH(W)) bus();

  urate_mul_acc #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            k <= '0;
    else if (sob_clr)      k <= '0;
    else if (bus.sobol_en) k <= k + 16'd1;
  end
  assign bus.sobol_seq = bitrev(k);

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int t, n, stl, en_cnt, en_err, ob_err, lat;
    logic prev_c, prev_p, exp_en, p;
    @(negedge clk);
    bus.iA = v.ia; bus.cycles = v.cyc; bus.start = 1'b1; sob_clr = 1'b1;
    bus.iB_valid = 1'b0; bus.iB_bit = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; sob_clr = 1'b0;
    t = 1; n = 0; stl = 0; en_cnt = 0; en_err = 0; ob_err = 0; lat = -1;
    prev_c = 1'b0; prev_p = 1'b0;
    while (t <= v.exp_lat + 50) begin
      if (bus.oBit_valid !== prev_c || (prev_c && bus.oBit !== prev_p)) ob_err++;
      if (bus.done === 1'b1) begin lat = t; break; end
      if (t == v.poke) begin
        bus.start = 1'b1; bus.iA = 16'hFFFF; bus.cycles = 17'd5;
      end else if (t == v.poke + 1) begin
        bus.start = 1'b0; bus.iA = v.ia; bus.cycles = v.cyc;
      end
      if (n == v.stall_at && stl < v.stall_len) begin
        bus.iB_valid = 1'b0; stl++;
      end else bus.iB_valid = 1'b1;
      bus.iB_bit = (v.alt != 0) ? (n % 2 == 0) : 1'b1;
      #1;
      exp_en = bus.iB_valid && (n < int'(v.cyc));
      if (bus.sobol_en !== exp_en) en_err++;
      if (bus.sobol_en === 1'b1) en_cnt++;
      p = bus.iB_bit & (v.ia > bus.sobol_seq);
      prev_c = exp_en; prev_p = p;
      if (exp_en) n++;
      @(negedge clk);
      t++;
    end
    bus.iB_valid = 1'b0;
    chk({nm, " done latency"}, lat, v.exp_lat);
    chk({nm, " oC"}, bus.oC, v.exp_oc);
    chk({nm, " sobol_en pulses"}, en_cnt, v.exp_en);
    chk({nm, " sobol_en cycle errors"}, en_err, 0);
    chk({nm, " oBit errors"}, ob_err, 0);
    chk({nm, " busy in done"}, bus.busy, 0);
    @(negedge clk);
    chk({nm, " done one cycle"}, bus.done, 0);
    chk({nm, " oC held"}, bus.oC, v.exp_oc);
  endtask

  initial begin
    vecs[0] = '{16'h4000, 17'd16,    0, -1, 0, -1, 17'd4,     17,    16};
    vecs[1] = '{16'hFFFF, 17'd16,    1, -1, 0, -1, 17'd8,     17,    16};
    vecs[2] = '{16'h4000, 17'd16,    0,  7, 5, -1, 17'd4,     22,    16};
    vecs[3] = '{16'h4000, 17'd0,     0, -1, 0, -1, 17'd0,     1,     0};
    vecs[4] = '{16'h4000, 17'd16,    0, -1, 0,  3, 17'd4,     17,    16};
    vecs[5] = '{16'h8000, 17'd65536, 0, -1, 0, -1, 17'd32768, 65537, 65536};

    bus.start = 1'b0; bus.iA = '0; bus.cycles = '0; bus.iB_bit = 1'b0; bus.iB_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset oBit_valid", bus.oBit_valid, 0);
    chk("reset oC", bus.oC, 0);
    chk("idle sobol_en", bus.sobol_en, 0);

    for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a window
    @(negedge clk);
    bus.iA = 16'h4000; bus.cycles = 17'd16; bus.start = 1'b1; sob_clr = 1'b1;
    bus.iB_valid = 1'b1; bus.iB_bit = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; sob_clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre-reset oC", bus.oC, 2);
    chk("pre-reset busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async busy", bus.busy, 0);
    chk("async done", bus.done, 0);
    chk("async oBit_valid", bus.oBit_valid, 0);
    chk("async oC", bus.oC, 0);
    chk("async sobol_en", bus.sobol_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(vecs[0], "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
